fsub_pipe: RTL

// - Pipelined IEEE-754 single-precision subtractor: dest = src - sink.
// - Counterpart of the combinational fadd, in the opposite arithmetic direction.

---
 rtl/fsub_pipe_if.sv | 22 ++
 rtl/fsub_pipe.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/fsub_pipe_if.sv
// Operand/result stream between the FPU issue logic and writeback for the subtract pipe.
// master = issuer plus consumer side, slave = the pipe itself.
interface fsub_pipe_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] src;
    logic [31:0] sink;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] dest;
    logic        ovf;

    modport master (
        output in_valid, src, sink, out_ready,
        input  in_ready, out_valid, dest, ovf
    );

    modport slave (
        input  in_valid, src, sink, out_ready,
        output in_ready, out_valid, dest, ovf
    );
endinterface

// File: rtl/fsub_pipe.sv
// Pipelined single-precision subtract dest = src - sink: align stage, then normalize/round stage.
// Latency 2 cycles, 1 cycle when FSUB_PIPE_BYPASS_EN is defined (align register removed); 1 op/cycle.
// Backpressure: global stall, in_ready = !out_valid | out_ready; every stage holds while it is low.
module fsub_pipe (
    input  logic       clk,
    input  logic       rstn,
    fsub_pipe_if.slave io
);
    logic adv;
    assign adv         = !io.out_valid || io.out_ready;
    assign io.in_ready = adv;

    // Align: sink sign is flipped so the whole datapath is an add of signed magnitudes.
    logic        a_sign, b_sign, swap;
    logic [7:0]  a_exp, b_exp;
    logic [23:0] a_sig, b_sig, sm_sig;
    logic        al_sign, al_sub;
    logic [7:0]  al_exp, al_shift;
    logic [26:0] al_big, al_small;
    logic [49:0] sm_wide;

    always_comb begin
        a_sign   = io.src[31];
        a_exp    = io.src[30:23];
        a_sig    = (a_exp == 8'd0) ? 24'd0 : {1'b1, io.src[22:0]};
        b_sign   = ~io.sink[31];
        b_exp    = io.sink[30:23];
        b_sig    = (b_exp == 8'd0) ? 24'd0 : {1'b1, io.sink[22:0]};
        swap     = {b_exp, b_sig} > {a_exp, a_sig};
        al_sign  = swap ? b_sign : a_sign;
        al_exp   = swap ? b_exp : a_exp;
        al_sub   = a_sign ^ b_sign;
        al_big   = {(swap ? b_sig : a_sig), 3'b000};
        sm_sig   = swap ? a_sig : b_sig;
        al_shift = al_exp - (swap ? a_exp : b_exp);
        sm_wide  = {sm_sig, 26'd0} >> al_shift;
        // Layout {hidden, man[22:0], guard, round, sticky}
        if (al_shift >= 8'd26)
            al_small = {26'd0, |sm_sig};
        else
            al_small = {sm_wide[49:24], |sm_wide[23:0]};
    end

    logic        st_vld, st_sign, st_sub;
    logic [7:0]  st_exp;
    logic [26:0] st_big, st_small;

`ifdef FSUB_PIPE_BYPASS_EN
    assign st_vld   = io.in_valid;
    assign st_sign  = al_sign;
    assign st_sub   = al_sub;
    assign st_exp   = al_exp;
    assign st_big   = al_big;
    assign st_small = al_small;
`else
    logic        s1_vld, s1_sign, s1_sub;
    logic [7:0]  s1_exp;
    logic [26:0] s1_big, s1_small;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_vld   <= 1'b0;
            s1_sign  <= 1'b0;
            s1_sub   <= 1'b0;
            s1_exp   <= 8'd0;
            s1_big   <= 27'd0;
            s1_small <= 27'd0;
        end else if (adv) begin
            s1_vld   <= io.in_valid;
            s1_sign  <= al_sign;
            s1_sub   <= al_sub;
            s1_exp   <= al_exp;
            s1_big   <= al_big;
            s1_small <= al_small;
        end
    end

    assign st_vld   = s1_vld;
    assign st_sign  = s1_sign;
    assign st_sub   = s1_sub;
    assign st_exp   = s1_exp;
    assign st_big   = s1_big;
    assign st_small = s1_small;
`endif

    logic [27:0]       sum;
    logic [4:0]        lzc;
    logic [26:0]       norm;
    logic signed [9:0] exp_n, exp_r;
    logic              round_up;
    logic [24:0]       rnd;
    logic [31:0]       res;
    logic              res_ovf;

    always_comb begin
        sum = st_sub ? ({1'b0, st_big} - {1'b0, st_small})
                     : ({1'b0, st_big} + {1'b0, st_small});
        lzc = 5'd26;
        for (int i = 0; i < 27; i++)
            if (sum[i]) lzc = 5'(26 - i);
        if (sum[27]) begin
            norm  = {sum[27:2], sum[1] | sum[0]};
            exp_n = $signed({2'b00, st_exp}) + 10'sd1;
        end else begin
            norm  = sum[26:0] << lzc;
            exp_n = $signed({2'b00, st_exp}) - $signed({5'd0, lzc});
        end
        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        rnd      = {1'b0, norm[26:3]} + {24'd0, round_up};
        exp_r    = exp_n + (rnd[24] ? 10'sd1 : 10'sd0);
        res_ovf  = 1'b0;
        // A zero sum under effective subtraction is exact cancellation and yields +0.
        if (sum == 28'd0)
            res = {(st_sub ? 1'b0 : st_sign), 31'd0};
        else if (exp_n <= 10'sd0)
            res = {st_sign, 31'd0};
        else if (exp_r >= 10'sd255) begin
            res     = {st_sign, 8'hFF, 23'd0};
            res_ovf = 1'b1;
        end else
            res = {st_sign, exp_r[7:0], (rnd[24] ? rnd[23:1] : rnd[22:0])};
    end

    logic        out_vld;
    logic [31:0] dest_q;
    logic        ovf_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_vld <= 1'b0;
            dest_q  <= 32'd0;
            ovf_q   <= 1'b0;
        end else if (adv) begin
            out_vld <= st_vld;
            if (st_vld) begin
                dest_q <= res;
                ovf_q  <= res_ovf;
            end
        end
    end

    assign io.out_valid = out_vld;
    assign io.dest      = dest_q;
    assign io.ovf       = ovf_q;
endmodule
